// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: requester identity and owner-FIFO entry.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   kill;
  } arb_ent_t;

  localparam int unsigned MAX_OUTS_DEF = 2;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order record of who owns each outstanding memory transaction, with a bulk
// kill-mark for IFU entries that never touches the entry being pushed this cycle.
module arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTS_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  owner_e   push_owner_i,
  input  logic     pop_i,
  input  logic     kill_ifu_i,
  output logic     full_o,
  output logic     empty_o,
  output arb_ent_t head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  arb_ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Stale slots may get marked too; harmless, since a push rewrites kill=0.
    if (kill_ifu_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_q[i].owner == OWN_IFU) ent_d[i].kill = 1'b1;
      end
    end
    if (push_i) begin
      ent_d[wr_ptr_q].owner = push_owner_i;
      ent_d[wr_ptr_q].kill  = 1'b0;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop_i) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ent_q    <= ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = ent_q[rd_ptr_q];

endmodule

// File: rtl/mem_arb.sv
// Round-robin IFU/LSU arbiter for the single memory port, with grant lock while
// a request stalls and in-order response routing that drops flushed fetches.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_OUTS = MAX_OUTS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_vld,
  output logic                ifu_req_rdy,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_vld,
  input  logic                ifu_rsp_rdy,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  input  logic                ifu_fl,
  input  logic                lsu_req_vld,
  output logic                lsu_req_rdy,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_we,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  output logic                lsu_rsp_vld,
  input  logic                lsu_rsp_rdy,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_vld,
  input  logic                mem_req_rdy,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_rsp_vld,
  output logic                mem_rsp_rdy,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  logic     lock_q, lock_d;
  owner_e   lock_owner_q, lock_owner_d;
  owner_e   last_gnt_q, last_gnt_d;
  owner_e   gnt;
  logic     gnt_vld;
  logic     req_vld;
  logic     req_hs;
  logic     rsp_hs;
  logic     fifo_full;
  logic     fifo_empty;
  arb_ent_t head;

  always_comb begin
    gnt = OWN_LSU;
    if (lock_q) begin
      gnt = lock_owner_q;
    end else if (ifu_req_vld && !lsu_req_vld) begin
      gnt = OWN_IFU;
    end else if (ifu_req_vld && lsu_req_vld) begin
      gnt = (last_gnt_q == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end
  end

  assign gnt_vld = (gnt == OWN_IFU) ? ifu_req_vld : lsu_req_vld;
  assign req_vld = gnt_vld && !fifo_full && !rst;
  assign req_hs  = req_vld && mem_req_rdy;
  assign rsp_hs  = mem_rsp_vld && mem_rsp_rdy;

  always_comb begin
    mem_req_vld   = req_vld;
    ifu_req_rdy   = !rst && (gnt == OWN_IFU) && mem_req_rdy && !fifo_full;
    lsu_req_rdy   = !rst && (gnt == OWN_LSU) && mem_req_rdy && !fifo_full;
    mem_req_addr  = '0;
    mem_req_we    = 1'b0;
    mem_req_wstrb = '0;
    mem_req_wdata = '0;
    if (req_vld) begin
      if (gnt == OWN_LSU) begin
        mem_req_addr  = lsu_req_addr;
        mem_req_we    = lsu_req_we;
        mem_req_wstrb = lsu_req_wstrb;
        mem_req_wdata = lsu_req_wdata;
      end else begin
        mem_req_addr  = ifu_req_addr;
      end
    end
  end

  always_comb begin
    ifu_rsp_vld  = 1'b0;
    lsu_rsp_vld  = 1'b0;
    mem_rsp_rdy  = 1'b0;
    ifu_rsp_data = rst ? '0 : mem_rsp_data;
    lsu_rsp_data = rst ? '0 : mem_rsp_data;
    if (!rst && !fifo_empty) begin
      if (head.owner == OWN_LSU) begin
        lsu_rsp_vld = mem_rsp_vld;
        mem_rsp_rdy = lsu_rsp_rdy;
      end else if (!head.kill) begin
        ifu_rsp_vld = mem_rsp_vld;
        mem_rsp_rdy = ifu_rsp_rdy;
      end else begin
        // Flushed fetch: swallow the response without bothering the IFU.
        mem_rsp_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    last_gnt_d   = last_gnt_q;
    if (req_hs) begin
      lock_d     = 1'b0;
      last_gnt_d = gnt;
    end else if (req_vld) begin
      lock_d       = 1'b1;
      lock_owner_d = gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_IFU;
      last_gnt_q   <= OWN_IFU;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  arb_owner_fifo #(
    .DEPTH(MAX_OUTS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (req_hs),
    .push_owner_i(gnt),
    .pop_i       (rsp_hs),
    .kill_ifu_i  (ifu_fl && !rst),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  a_rsp_without_owner : assert property (
    @(posedge clk) disable iff (rst) !(mem_rsp_vld && fifo_empty)
  );

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-requester arbiter for the core's single memory port: the IFU fetch channel and the LSU data channel.
- Applies round-robin with grant lock, then tracks outstanding transactions in an in-order owner FIFO.
- Routes each memory response back to its originator.
- On an IFU flush, drops responses to fetches that are already in flight.
- Sits between ifu/lsu and the bus/memory adapter.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data width; wstrb width is DATA_W/8
MAX_OUTS, 2, max outstanding memory transactions (owner FIFO depth, >=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ifu_req_vld  in  1  fetch request valid
ifu_req_rdy  out  1  fetch request ready
ifu_req_addr  in  ADDR_W  fetch address (pc)
ifu_rsp_vld  out  1  fetch response valid
ifu_rsp_rdy  in  1  fetch response ready
ifu_rsp_data  out  DATA_W  fetched instruction word
ifu_fl  in  1  flush pulse: discard in-flight fetches
lsu_req_vld  in  1  data request valid
lsu_req_rdy  out  1  data request ready
lsu_req_addr  in  ADDR_W  data address
lsu_req_we  in  1  write enable
lsu_req_wstrb  in  DATA_W/8  byte strobes
lsu_req_wdata  in  DATA_W  write data
lsu_rsp_vld  out  1  data response valid (load data or write ack)
lsu_rsp_rdy  in  1  data response ready
lsu_rsp_data  out  DATA_W  load data (don't-care for writes)
mem_req_vld  out  1  memory request valid
mem_req_rdy  in  1  memory request ready
mem_req_addr  out  ADDR_W  muxed address
mem_req_we  out  1  muxed write enable (0 for IFU)
mem_req_wstrb  out  DATA_W/8  muxed strobes (0 for IFU)
mem_req_wdata  out  DATA_W  muxed write data (0 for IFU)
mem_rsp_vld  in  1  memory response valid
mem_rsp_rdy  out  1  memory response ready
mem_rsp_data  in  DATA_W  response data

Behaviour:

Reset:
- All outputs are 0 while rst=1 and after reset.
- Owner FIFO is empty; last_gnt=IFU, so LSU wins the first tie; lock=0.

Handshake rule:
- A transfer occurs when vld & rdy on the same clk edge.
- Requesters must hold vld and payload stable until accepted; the arbiter obeys the same rule on mem_req.

Grant (combinational unless locked):
- If lock=1, the grant is the locked owner.
- Otherwise, if only one requester is valid, it is granted.
- If both are valid, the requester that is not last_gnt is granted.
- Routing: mem_req_vld = granted requester's vld & ~fifo_full; payload is muxed from the granted requester.
- Granted requester's req_rdy = mem_req_rdy & ~fifo_full; the non-granted requester's req_rdy = 0.
- lock is set when mem_req_vld & ~mem_req_rdy, and holds the owner. It clears on mem_req handshake.
- last_gnt updates on every mem_req handshake.

Owner FIFO:
- Push {owner, kill=0} on every mem_req handshake (writes included: every request gets exactly one response).
- fifo_full blocks new requests even if a pop occurs in the same cycle. There is no combinational rsp->req path.
- Zero-cycle turnaround: a response may arrive in the cycle after the request handshake.

Response routing (uses the FIFO head):
- Head owner = LSU: lsu_rsp_vld = mem_rsp_vld; mem_rsp_rdy = lsu_rsp_rdy.
- Head owner = IFU and kill=0: ifu_rsp_vld = mem_rsp_vld; mem_rsp_rdy = ifu_rsp_rdy.
- Head owner = IFU and kill=1: mem_rsp_rdy = 1 and ifu_rsp_vld = 0 (the response is silently consumed).
- Data outputs are mem_rsp_data passed through to both requesters.
- FIFO pops on mem_rsp handshake.
- FIFO empty: mem_rsp_rdy = 0, and a simulation assertion fires if mem_rsp_vld=1.

Flush:
- On ifu_fl=1, set kill on every valid FIFO entry with owner=IFU.
- Entries pushed in the same cycle are not killed (a post-redirect fetch survives).
- An entry popped in the same cycle is delivered normally.
- A locked but not-yet-accepted IFU request is not cancelled.
- LSU entries are never affected.

Latency: request path is 0 cycles (combinational); response path is 0 cycles.

Pointer arithmetic:
- wr/rd pointers are $clog2(MAX_OUTS) bits with wrap at MAX_OUTS-1, plus a count register of 0..MAX_OUTS.
- Simultaneous push and pop leaves count unchanged.

Reset mid-operation: FIFO, lock and last_gnt clear immediately; in-flight memory responses are the environment's responsibility.

Decomposition:
- mem_arb_pkg holds:
  - owner_e enum {OWN_IFU, OWN_LSU}
  - arb_ent_t struct {owner_e owner; logic kill}
  - the MAX_OUTS default constant
- Sub-module arb_owner_fifo provides:
  - push/pop, full/empty and head
  - a bulk kill-mark input that sets kill on IFU entries, excluding the same-cycle push

Test Plan:
- Both requesters valid after reset, mem_req_rdy=1 -> LSU granted first, then IFU, then LSU, strictly alternating while both stay valid.
- IFU valid, mem_req_rdy=0 for 3 cycles while LSU becomes valid in cycle 2 -> mem_req_addr holds the IFU address all 4 cycles; LSU is granted only after the IFU handshake.
- MAX_OUTS=2, two IFU fetches accepted with no responses -> ifu_req_rdy=0 and mem_req_vld=0 until the first mem_rsp handshake, and remain 0 in the pop cycle itself.
- Outstanding IFU A, LSU B, IFU C; ifu_fl asserted before any response; responses D0, D1, D2 -> ifu_rsp_vld never asserts; lsu_rsp_vld asserts with D1; mem_rsp_rdy=1 for D0 and D2.
- ifu_fl in the same cycle as an IFU request handshake at 0x100 -> the response to 0x100 is delivered on ifu_rsp with the correct data.
- rst asserted with 2 entries outstanding -> all outputs 0 immediately; after deassert, the first tie grants LSU.
